// File: rtl/adc_sample_rx.sv
// Serial ADC receiver: frames a 16-bit read every SAMPLE_PERIOD clocks and strobes the word out.
// Build option: define ADC_RX_OFFSET_BIN_EN when the ADC delivers offset-binary words.
module adc_sample_rx #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        adc_sdo,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    input  logic        clr_ovr,
    output logic [15:0] xOut,
    output logic        sample,
    output logic        overrun,
    output logic [1:0]  o_dbg_state
);
    localparam int SHIFT_LEN = 32 * CLK_DIV;
    localparam int SC_W      = $clog2(SHIFT_LEN);
    localparam int DIV_W     = $clog2(CLK_DIV + 1);
    localparam int PCNT_W    = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [PCNT_W-1:0]  r_pcnt;
    logic [SC_W-1:0]    r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nx;
    logic               r_sclk;
    logic               w_sclk_nx;
    logic               r_cs_n;
    logic [15:0]        r_shift;
    logic [15:0]        r_xout;
    logic [15:0]        w_word;
    logic               r_sample;
    logic               r_overrun;
    logic               w_tick;
    logic               w_shift_last;
    logic               w_rise;

`ifdef ADC_RX_OFFSET_BIN_EN
    assign w_word = {~r_shift[15], r_shift[14:0]};
`else
    assign w_word = r_shift;
`endif

    assign w_tick       = en && (r_pcnt == '0);
    assign w_shift_last = (r_cnt == SC_W'(SHIFT_LEN - 1));
    assign w_rise       = w_sclk_nx && !r_sclk;

    always_comb begin
        w_state_nx = r_state;
        w_sclk_nx  = 1'b0;
        w_div_nx   = '0;
        case (r_state)
            S_IDLE:     if (w_tick) w_state_nx = S_CS_SETUP;
            S_CS_SETUP: w_state_nx = S_SHIFT;
            S_SHIFT: begin
                // sclk half-periods are timed by r_div; the last SHIFT cycle drops sclk for DONE
                w_div_nx = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
                if (w_shift_last) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_sclk_nx = (r_div == DIV_W'(CLK_DIV - 1)) ? ~r_sclk : r_sclk;
                end
            end
            S_DONE:     w_state_nx = S_IDLE;
            default:    w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pcnt    <= '0;
            r_cnt     <= '0;
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_shift   <= '0;
            r_xout    <= '0;
            r_sample  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cs_n   <= !((w_state_nx == S_CS_SETUP) || (w_state_nx == S_SHIFT));
            r_sclk   <= w_sclk_nx;
            r_div    <= w_div_nx;
            r_cnt    <= (r_state == S_SHIFT) ? r_cnt + SC_W'(1) : '0;
            r_sample <= (w_state_nx == S_DONE);
            if (w_rise) begin
                r_shift <= {r_shift[14:0], adc_sdo};
            end
            if (w_state_nx == S_DONE) begin
                r_xout <= w_word;
            end
            if (!en) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= (r_pcnt == PCNT_W'(SAMPLE_PERIOD - 1)) ? '0 : r_pcnt + PCNT_W'(1);
            end
            // a late tick never restarts the frame; set wins over clear
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign adc_sclk    = r_sclk;
    assign adc_cs_n    = r_cs_n;
    assign xOut        = r_xout;
    assign sample      = r_sample;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_adc_sample_rx.sv
// Bench for adc_sample_rx: default build instance plus a CLK_DIV=1 / SAMPLE_PERIOD=35 instance.
module tb_adc_sample_rx;
`ifdef ADC_RX_OFFSET_BIN_EN
    localparam logic [15:0] OFS = 16'h8000;
`else
    localparam logic [15:0] OFS = 16'h0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        reset0 = 1'b1, en0 = 1'b0, clr0 = 1'b0;
    logic        sclk0, cs_n0, smp0, ovr0;
    logic        sdo0;
    logic [15:0] x0;
    logic [1:0]  st0;
    logic        reset1 = 1'b1, en1 = 1'b0, clr1 = 1'b0;
    logic        sclk1, cs_n1, smp1, ovr1;
    logic        sdo1;
    logic [15:0] x1;
    logic [1:0]  st1;

    adc_sample_rx dut0 (
        .clk(clk), .reset(reset0), .en(en0), .adc_sdo(sdo0), .adc_sclk(sclk0),
        .adc_cs_n(cs_n0), .clr_ovr(clr0), .xOut(x0), .sample(smp0), .overrun(ovr0),
        .o_dbg_state(st0)
    );

    adc_sample_rx #(.CLK_DIV(1), .SAMPLE_PERIOD(35)) dut1 (
        .clk(clk), .reset(reset1), .en(en1), .adc_sdo(sdo1), .adc_sclk(sclk1),
        .adc_cs_n(cs_n1), .clr_ovr(clr1), .xOut(x1), .sample(smp1), .overrun(ovr1),
        .o_dbg_state(st1)
    );

    // ADC models: a word is fetched on chip-select fall, bit (15 - rises) presented on sdo
    logic [15:0] wq0[$];
    logic [15:0] wq1[$];
    logic [15:0] cur0 = '0, cur1 = '0;
    int          rises0 = 16, rises1 = 16;

    always @(negedge cs_n0 or posedge sclk0) begin
        if (!cs_n0 && sclk0) begin
            rises0 = rises0 + 1;
        end else begin
            cur0   = (wq0.size() > 0) ? wq0.pop_front() : 16'($urandom);
            rises0 = 0;
        end
    end
    assign sdo0 = (rises0 < 16) ? cur0[4'(15 - rises0)] : 1'b0;

    always @(negedge cs_n1 or posedge sclk1) begin
        if (!cs_n1 && sclk1) begin
            rises1 = rises1 + 1;
        end else begin
            cur1   = (wq1.size() > 0) ? wq1.pop_front() : 16'($urandom);
            rises1 = 0;
        end
    end
    assign sdo1 = (rises1 < 16) ? cur1[4'(15 - rises1)] : 1'b0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart0();
        en0 = 1'b0; clr0 = 1'b0; reset0 = 1'b1;
        step(); step();
        wq0.delete();
        reset0 = 1'b0;
    endtask

    task automatic test_reset();
        step(); step(); step();
        total++; if (cs_n0 !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n0); end
        total++; if (sclk0 !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk0); end
        total++; if (x0 !== 16'h0000) begin bad++; $display("FAIL reset_xout got=%h exp=0000", x0); end
        total++; if (smp0 !== 1'b0) begin bad++; $display("FAIL reset_sample got=%b exp=0", smp0); end
        total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", ovr0); end
        total++; if (cs_n1 !== 1'b1) begin bad++; $display("FAIL reset_cs_n_fast got=%b exp=1", cs_n1); end
    endtask

    // A5C3 first, then the boundary words, then random words, en held high throughout
    task automatic test_stream();
        logic [15:0] w[6];
        int n = 0;
        w[0] = 16'hA5C3; w[1] = 16'h0001; w[2] = 16'h8000; w[3] = 16'h7FFF;
        w[4] = 16'($urandom); w[5] = 16'($urandom);
        restart0();
        for (int i = 0; i < 6; i++) wq0.push_back(w[i]);
        en0 = 1'b1;
        total++; if (cs_n0 !== 1'b1) begin bad++; $display("FAIL stream_cs_idle got=%b exp=1", cs_n0); end
        for (int k = 1; k <= 6 * 96 + 70; k++) begin
            step();
            if (k == 1) begin
                total++; if (cs_n0 !== 1'b0) begin bad++; $display("FAIL stream_cs_low k=1 got=%b exp=0", cs_n0); end
            end
            if (cs_n0 === 1'b1) begin
                total++; if (sclk0 !== 1'b0) begin bad++; $display("FAIL stream_sclk_idle k=%0d got=%b exp=0", k, sclk0); end
            end
            if (smp0 === 1'b1) begin
                total++; if (k != 66 + 96 * n) begin bad++; $display("FAIL stream_time n=%0d got=%0d exp=%0d", n, k, 66 + 96 * n); end
                total++; if (x0 !== (w[n] ^ OFS)) begin bad++; $display("FAIL stream_xout n=%0d got=%h exp=%h", n, x0, w[n] ^ OFS); end
                total++; if (rises0 != 16) begin bad++; $display("FAIL stream_rises n=%0d got=%0d exp=16", n, rises0); end
                n++;
                if (n == 6) break;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL stream_count got=%0d exp=6", n); end
        total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL stream_overrun got=%b exp=0", ovr0); end
    endtask

    task automatic test_en_glitch();
        logic [15:0] w = 16'($urandom);
        int first = -1;
        int cnt = 0;
        restart0();
        wq0.push_back(w);
        en0 = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            step();
            if (smp0 === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 12) begin
                total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL glitch_ovr_pre got=%b exp=0", ovr0); end
            end
            if (k == 13) begin
                total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL glitch_ovr_set got=%b exp=1", ovr0); end
                total++; if (cs_n0 !== 1'b0) begin bad++; $display("FAIL glitch_cs_held got=%b exp=0", cs_n0); end
            end
            if (k == 71) begin
                total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL glitch_ovr_clr got=%b exp=0", ovr0); end
            end
            en0  = (k == 10 || k == 11) ? 1'b0 : 1'b1;
            clr0 = (k == 70);
        end
        total++; if (first != 66) begin bad++; $display("FAIL glitch_time got=%0d exp=66", first); end
        total++; if (cnt != 1) begin bad++; $display("FAIL glitch_strobes got=%0d exp=1", cnt); end
        total++; if (x0 !== (w ^ OFS)) begin bad++; $display("FAIL glitch_xout got=%h exp=%h", x0, w ^ OFS); end
    endtask

    task automatic test_ovr_collision();
        restart0();
        en0 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 13) begin
                total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL collide_ovr got=%b exp=1", ovr0); end
            end
            en0  = (k == 10 || k == 11) ? 1'b0 : 1'b1;
            clr0 = (k == 11 || k == 12);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w[3];
        int ts[$];
        logic [15:0] xs[$];
        w[0] = 16'h1234; w[1] = 16'($urandom); w[2] = 16'($urandom);
        restart0();
        for (int i = 0; i < 3; i++) wq0.push_back(w[i]);
        en0 = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (smp0 === 1'b1) begin
                ts.push_back(k);
                xs.push_back(x0);
            end
            if (k == 126) begin
                total++; if (x0 !== (w[0] ^ OFS)) begin bad++; $display("FAIL rst_pre_xout got=%h exp=%h", x0, w[0] ^ OFS); end
            end
            if (k == 127) begin
                total++; if (cs_n0 !== 1'b1) begin bad++; $display("FAIL rst_cs_n got=%b exp=1", cs_n0); end
                total++; if (sclk0 !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", sclk0); end
                total++; if (x0 !== 16'h0000) begin bad++; $display("FAIL rst_xout got=%h exp=0000", x0); end
                total++; if (smp0 !== 1'b0) begin bad++; $display("FAIL rst_sample got=%b exp=0", smp0); end
            end
            if (k == 129) begin
                total++; if (cs_n0 !== 1'b0) begin bad++; $display("FAIL rst_restart_cs got=%b exp=0", cs_n0); end
            end
            reset0 = (k == 126 || k == 127);
        end
        total++; if (ts.size() != 2) begin bad++; $display("FAIL rst_strobes got=%0d exp=2", ts.size()); end
        if (ts.size() == 2) begin
            total++; if (ts[0] != 66) begin bad++; $display("FAIL rst_time0 got=%0d exp=66", ts[0]); end
            total++; if (ts[1] != 194) begin bad++; $display("FAIL rst_time1 got=%0d exp=194", ts[1]); end
            total++; if (xs[1] !== (w[2] ^ OFS)) begin bad++; $display("FAIL rst_xout1 got=%h exp=%h", xs[1], w[2] ^ OFS); end
        end
    endtask

    task automatic test_fast();
        logic [15:0] w[6];
        int n = 0;
        for (int i = 0; i < 6; i++) begin
            w[i] = 16'($urandom);
            wq1.push_back(w[i]);
        end
        reset1 = 1'b0;
        en1    = 1'b1;
        for (int k = 1; k <= 6 * 35 + 50; k++) begin
            step();
            if (cs_n1 === 1'b1) begin
                total++; if (sclk1 !== 1'b0) begin bad++; $display("FAIL fast_sclk_idle k=%0d got=%b exp=0", k, sclk1); end
            end
            if (smp1 === 1'b1) begin
                total++; if (k != 34 + 35 * n) begin bad++; $display("FAIL fast_time n=%0d got=%0d exp=%0d", n, k, 34 + 35 * n); end
                total++; if (x1 !== (w[n] ^ OFS)) begin bad++; $display("FAIL fast_xout n=%0d got=%h exp=%h", n, x1, w[n] ^ OFS); end
                total++; if (rises1 != 16) begin bad++; $display("FAIL fast_rises n=%0d got=%0d exp=16", n, rises1); end
                n++;
                if (n == 6) break;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL fast_count got=%0d exp=6", n); end
        total++; if (ovr1 !== 1'b0) begin bad++; $display("FAIL fast_overrun got=%b exp=0", ovr1); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_en_glitch();
        test_ovr_collision();
        test_reset_mid_frame();
        test_fast();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_sample_rx.md
ADC_SAMPLE_RX -- requirements
Module: adc_sample_rx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2: clk cycles per sclk half-period; legal range 1..8.
REQ-002 The block SHALL have parameter SAMPLE_PERIOD, default 96: clk cycles between frame starts; legal only when it is at least 32*CLK_DIV+3.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic rises on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: enables sample-period ticks.
REQ-006 The block SHALL have port adc_sdo, input, 1 bit: ADC serial data, MSB first.
REQ-007 The block SHALL have port adc_sclk, output, 1 bit: ADC serial clock, registered, idles low.
REQ-008 The block SHALL have port adc_cs_n, output, 1 bit: ADC chip select, registered, active low.
REQ-009 The block SHALL have port clr_ovr, input, 1 bit: clears overrun.
REQ-010 The block SHALL have port xOut, output, 16 bits: last received sample, two's complement, feeds the FIR xIn.
REQ-011 The block SHALL have port sample, output, 1 bit: one-clk strobe marking xOut valid, feeds the FIR sample input.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky overrun flag.

Function
REQ-013 Period counter pcnt: while en=1, counts 0..SAMPLE_PERIOD-1 and wraps; while en=0, held at 0; tick = (en=1 and pcnt=0).
REQ-014 FSM states: IDLE, CS_SETUP, SHIFT, DONE. IDLE->CS_SETUP on tick; CS_SETUP->SHIFT after 1 cycle; SHIFT->DONE after 32*CLK_DIV cycles; DONE->IDLE after 1 cycle.
REQ-015 adc_cs_n SHALL be 0 in CS_SETUP and SHIFT, and 1 in IDLE and DONE.
REQ-016 In SHIFT, adc_sclk SHALL toggle every CLK_DIV cycles starting low, giving 16 rising edges; it SHALL be 0 outside SHIFT.
REQ-017 adc_sdo SHALL be captured into the shift register on the clk edge where adc_sclk goes 0->1, MSB first, 16 bits total.
REQ-018 Latency: for a tick at cycle t, sample=1 and the new xOut SHALL be visible at cycle t+2+32*CLK_DIV (t+66 at defaults); sample is high for exactly 1 cycle.
REQ-019 xOut SHALL hold its value between DONE states; sample=0 in all other states.
REQ-020 A tick while the FSM is not IDLE SHALL be ignored (no restart, frame continues) and SHALL set overrun=1.
REQ-021 overrun SHALL clear on clr_ovr=1; a simultaneous set and clear SHALL leave overrun=1.
REQ-022 en falling mid-frame SHALL NOT abort the frame; the in-flight sample still completes.
REQ-023 Consecutive sample strobes SHALL be at least SAMPLE_PERIOD cycles apart, which is never less than 33 and satisfies the FIR's 32-cycle MAC budget.

Reset
REQ-024 While reset=1: adc_cs_n=1, adc_sclk=0, xOut=0, sample=0, overrun=0, pcnt=0, FSM=IDLE, shift register=0.
REQ-025 Reset mid-frame SHALL abort the frame, with adc_cs_n=1 on the next cycle and no sample strobe; reset SHALL have priority over en, tick and clr_ovr.

Configuration
REQ-026 Macro ADC_RX_OFFSET_BIN_EN: when defined, the received word is offset-binary and xOut SHALL be the captured word with bit 15 inverted; when undefined, xOut SHALL be the captured word unchanged.

Verification
REQ-027 Defaults, reset then en=1, ADC model drives 16'hA5C3 -> cs_n low at t+1, 16 sclk rises, sample at t+66, xOut=16'hA5C3 (16'h25C3 with ADC_RX_OFFSET_BIN_EN).
REQ-028 en=1 continuously, words 16'h0001, 16'h8000, 16'h7FFF -> sample strobes exactly 96 cycles apart, xOut matches in order, overrun=0.
REQ-029 en toggled 1->0->1 at t+10..t+12 mid-frame -> tick at t+12 ignored, overrun=1, frame completes with sample at t+66; pulse clr_ovr -> overrun=0.
REQ-030 clr_ovr=1 held during an overrun-setting tick -> overrun=1 after that cycle.
REQ-031 reset asserted at t+30 mid-frame -> next cycle adc_cs_n=1, adc_sclk=0, xOut=0, no sample strobe; after reset release with en=1, a new frame starts immediately.
REQ-032 CLK_DIV=1, SAMPLE_PERIOD=35 -> sample at t+34 and every 35 cycles thereafter, all words correct.
